// File: rtl/phase_diff_avg_pkg.sv
// Shared constants and state encoding for the phase-difference averager.
package phase_diff_avg_pkg;

  // pi/2 at 7 fractional bits, identical to the CORDIC stage's base angle
  localparam int HALF_PI_Q7 = 201;

  // pi scaled to the requested number of fractional bits (402 at 7 bits)
  function automatic int pi_q(input int p_f);
    if (p_f >= 7) begin
      return (2 * HALF_PI_Q7) << (p_f - 7);
    end
    return (2 * HALF_PI_Q7) >> (7 - p_f);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRST = 2'd1,
    ST_ACC   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/phase_diff_avg_if.sv
// Sample-in / estimate-out handshake bundle for phase_diff_avg.
interface phase_diff_avg_if #(
  parameter int P_WL = 11
);
  logic                   i_start;
  logic                   i_abort;
  logic                   i_valid;
  logic signed [P_WL-1:0] i_phase;
  logic                   o_in_ready;
  logic                   o_valid;
  logic                   i_ready;
  logic signed [P_WL-1:0] o_freq;
  logic                   o_busy;

  // Driver side (stimulus / upstream controller)
  modport master (
    output i_start, i_abort, i_valid, i_phase, i_ready,
    input  o_in_ready, o_valid, o_freq, o_busy
  );

  // Averager side
  modport slave (
    input  i_start, i_abort, i_valid, i_phase, i_ready,
    output o_in_ready, o_valid, o_freq, o_busy
  );
endinterface

// File: rtl/phase_wrap_diff.sv
// Combinational phase difference cur - prev, folded once into [-pi, +pi].
module phase_wrap_diff
  import phase_diff_avg_pkg::*;
#(
  parameter int P_WL = 11,
  parameter int P_F  = 7
) (
  input  logic signed [P_WL-1:0] i_cur,
  input  logic signed [P_WL-1:0] i_prev,
  output logic signed [P_WL-1:0] o_d
);
  localparam logic signed [P_WL:0] PI_W     = (P_WL+1)'(pi_q(P_F));
  localparam logic signed [P_WL:0] TWO_PI_W = (P_WL+1)'(2 * pi_q(P_F));

  logic signed [P_WL:0] w_raw;
  logic signed [P_WL:0] w_wrap;

  // One extra bit for the raw difference; exactly +/-pi is left as is
  always_comb begin
    w_raw  = (P_WL+1)'(i_cur) - (P_WL+1)'(i_prev);
    w_wrap = w_raw;
    if (w_raw > PI_W) begin
      w_wrap = w_raw - TWO_PI_W;
    end else if (w_raw < -PI_W) begin
      w_wrap = w_raw + TWO_PI_W;
    end
    o_d = w_wrap[P_WL-1:0];
  end
endmodule

// File: rtl/phase_diff_avg.sv
// Averages 2^LOG2N wrapped phase differences into a per-sample frequency estimate.
module phase_diff_avg
  import phase_diff_avg_pkg::*;
#(
  parameter int P_WL   = 11,
  parameter int P_F    = 7,
  parameter int LOG2N  = 4,
  parameter int ACC_WL = P_WL + LOG2N
) (
  input  logic                i_clk,
  input  logic                i_rst,
  phase_diff_avg_if.slave     bus
);
  localparam logic [LOG2N-1:0] CNT_LAST = '1;

  state_t                   r_state;
  logic signed [ACC_WL-1:0] r_acc;
  logic [LOG2N-1:0]         r_cnt;
  logic signed [P_WL-1:0]   r_prev;
  logic signed [P_WL-1:0]   r_freq;
  logic                     r_in_ready;
  logic                     r_valid;
  logic                     r_busy;

  logic signed [P_WL-1:0]   w_d;
  logic signed [ACC_WL-1:0] w_d_ext;
  logic signed [ACC_WL-1:0] w_acc_sum;
  logic                     w_xfer;

  phase_wrap_diff #(
    .P_WL (P_WL),
    .P_F  (P_F)
  ) u_wrap (
    .i_cur  (bus.i_phase),
    .i_prev (r_prev),
    .o_d    (w_d)
  );

  // Sign-extended difference and the running sum including this sample
  assign w_d_ext   = ACC_WL'(w_d);
  assign w_acc_sum = r_acc + w_d_ext;
  assign w_xfer    = bus.i_valid & r_in_ready;

  assign bus.o_in_ready = r_in_ready;
  assign bus.o_valid    = r_valid;
  assign bus.o_freq     = r_freq;
  assign bus.o_busy     = r_busy;

  // Control FSM with datapath registers; handshake outputs are registered
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_prev     <= '0;
      r_freq     <= '0;
      r_in_ready <= 1'b0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
    end else if (bus.i_abort) begin
      // Partial sums and any pending estimate are simply dropped
      r_state    <= ST_IDLE;
      r_in_ready <= 1'b0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.i_start) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_state    <= ST_FIRST;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        ST_FIRST: begin
          // First sample only seeds the reference phase
          if (w_xfer) begin
            r_prev  <= bus.i_phase;
            r_state <= ST_ACC;
          end
        end
        ST_ACC: begin
          if (w_xfer) begin
            r_acc  <= w_acc_sum;
            r_prev <= bus.i_phase;
            r_cnt  <= r_cnt + 1'b1;
            if (r_cnt == CNT_LAST) begin
              // Arithmetic shift: mean rounds toward minus infinity
              r_freq     <= P_WL'(w_acc_sum >>> LOG2N);
              r_state    <= ST_DONE;
              r_in_ready <= 1'b0;
              r_valid    <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (bus.i_ready) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b0;
          r_valid    <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end
endmodule
